// File: rtl/ps2_host_tx_pkg.sv
// Shared definitions for the PS/2 host-to-device transmitter: states, frame payload, defaults.
package ps2_host_tx_pkg;

    localparam int unsigned PS2_FRAME_EDGES     = 11;
    localparam int unsigned PS2_EDGE_W          = 4;
    localparam int unsigned PS2_INHIBIT_DEFAULT = 2500;
    localparam int unsigned PS2_TIMEOUT_DEFAULT = 375000;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_INHIBIT   = 3'd1,
        ST_RTS       = 3'd2,
        ST_XFER      = 3'd3,
        ST_WAIT_IDLE = 3'd4
    } ps2_state_e;

    typedef struct packed {
        logic       parity;
        logic [7:0] data;
    } ps2_frame_t;

    function automatic logic odd_parity(input logic [7:0] d);
        return ~^d;
    endfunction

endpackage

// File: rtl/ps2_host_tx_line_sync.sv
// Two-flop synchronizers for the PS/2 clock and data pins plus a clock falling-edge strobe.
module ps2_host_tx_line_sync (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic ps2_clk_i,
    input  logic ps2_dat_i,
    output logic clk_sync_o,
    output logic dat_sync_o,
    output logic clk_fall_c
);

    logic clk_meta_q, clk_sync_q, clk_prev_q;
    logic dat_meta_q, dat_sync_q;

    // Reset to the idle-high line level so no spurious edge follows reset.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            clk_meta_q <= 1'b1;
            clk_sync_q <= 1'b1;
            clk_prev_q <= 1'b1;
            dat_meta_q <= 1'b1;
            dat_sync_q <= 1'b1;
        end else begin
            clk_meta_q <= ps2_clk_i;
            clk_sync_q <= clk_meta_q;
            clk_prev_q <= clk_sync_q;
            dat_meta_q <= ps2_dat_i;
            dat_sync_q <= dat_meta_q;
        end
    end

    assign clk_sync_o = clk_sync_q;
    assign dat_sync_o = dat_sync_q;
    assign clk_fall_c = clk_prev_q & ~clk_sync_q;

endmodule

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter: inhibit, request-to-send, 11-edge frame with ACK check and timeout.
module ps2_host_tx
    import ps2_host_tx_pkg::*;
#(
    parameter int unsigned INHIBIT_CYCLES = PS2_INHIBIT_DEFAULT,
    parameter int unsigned TIMEOUT_CYCLES = PS2_TIMEOUT_DEFAULT
) (
    input  logic       clk25,
    input  logic       rst_n,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    input  logic       ps2_clk_in,
    input  logic       ps2_dat_in,
    output logic       ps2_clk_oe,
    output logic       ps2_dat_oe,
    output logic       busy,
    output logic       done,
    output logic       error
);

    localparam int unsigned IW = $clog2(INHIBIT_CYCLES + 1);
    localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);

    ps2_state_e              state_q, state_d;
    ps2_frame_t              frame_q, frame_d;
    logic [IW-1:0]           inh_q, inh_d;
    logic [TW-1:0]           tmo_q, tmo_d;
    logic [PS2_EDGE_W-1:0]   edge_q, edge_d;
    logic clk_oe_q, clk_oe_d, dat_oe_q, dat_oe_d;
    logic busy_q, busy_d, ready_q, ready_d, done_q, done_d, err_q, err_d;
    logic clk_sync, dat_sync, clk_fall_c;
    logic accept_c, tmo_hit_c, nack_c;

    ps2_host_tx_line_sync u_sync (
        .clk_i      (clk25),
        .rst_ni     (rst_n),
        .ps2_clk_i  (ps2_clk_in),
        .ps2_dat_i  (ps2_dat_in),
        .clk_sync_o (clk_sync),
        .dat_sync_o (dat_sync),
        .clk_fall_c (clk_fall_c)
    );

    assign accept_c = tx_valid & ready_q;

    // State, datapath and registered outputs; reset releases both lines asynchronously.
    always_ff @(posedge clk25 or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            frame_q  <= '0;
            inh_q    <= '0;
            tmo_q    <= '0;
            edge_q   <= '0;
            clk_oe_q <= 1'b0;
            dat_oe_q <= 1'b0;
            busy_q   <= 1'b0;
            ready_q  <= 1'b1;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            frame_q  <= frame_d;
            inh_q    <= inh_d;
            tmo_q    <= tmo_d;
            edge_q   <= edge_d;
            clk_oe_q <= clk_oe_d;
            dat_oe_q <= dat_oe_d;
            busy_q   <= busy_d;
            ready_q  <= ready_d;
            done_q   <= done_d;
            err_q    <= err_d;
        end
    end

    // Next-state logic; timeout expiry takes priority over a same-cycle clock edge.
    always_comb begin
        state_d   = state_q;
        frame_d   = frame_q;
        inh_d     = inh_q;
        tmo_d     = tmo_q;
        edge_d    = edge_q;
        tmo_hit_c = 1'b0;
        nack_c    = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (accept_c) begin
                    frame_d.data   = tx_data;
                    frame_d.parity = odd_parity(tx_data);
                    inh_d          = '0;
                    tmo_d          = '0;
                    edge_d         = '0;
                    state_d        = ST_INHIBIT;
                end
            end
            ST_INHIBIT: begin
                if (inh_q == IW'(INHIBIT_CYCLES - 1)) state_d = ST_RTS;
                else                                  inh_d   = inh_q + 1'b1;
            end
            ST_RTS: state_d = ST_XFER;
            ST_XFER: begin
                tmo_d = tmo_q + 1'b1;
                if (tmo_q == TW'(TIMEOUT_CYCLES - 1)) begin
                    tmo_hit_c = 1'b1;
                    state_d   = ST_IDLE;
                end else if (clk_fall_c) begin
                    tmo_d  = '0;
                    edge_d = edge_q + 1'b1;
                    if (edge_q == PS2_EDGE_W'(PS2_FRAME_EDGES - 1)) begin
                        nack_c  = dat_sync;
                        state_d = dat_sync ? ST_IDLE : ST_WAIT_IDLE;
                    end
                end
            end
            ST_WAIT_IDLE: begin
                tmo_d = tmo_q + 1'b1;
                if (tmo_q == TW'(TIMEOUT_CYCLES - 1)) begin
                    tmo_hit_c = 1'b1;
                    state_d   = ST_IDLE;
                end else if (clk_sync && dat_sync) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Output values for the coming cycle, derived from the next state and bit index.
    always_comb begin
        clk_oe_d = 1'b0;
        dat_oe_d = 1'b0;
        ready_d  = (state_d == ST_IDLE);
        busy_d   = (state_d != ST_IDLE);
        done_d   = (state_q == ST_WAIT_IDLE) && (state_d == ST_IDLE) && !tmo_hit_c;
        err_d    = tmo_hit_c | nack_c;
        unique case (state_d)
            ST_INHIBIT: clk_oe_d = 1'b1;
            ST_RTS: begin
                clk_oe_d = 1'b1;
                dat_oe_d = 1'b1;
            end
            ST_XFER: begin
                if (edge_d == '0)          dat_oe_d = 1'b1;
                else if (edge_d <= 4'd8)   dat_oe_d = ~frame_q.data[3'(edge_d - 4'd1)];
                else if (edge_d == 4'd9)   dat_oe_d = ~frame_q.parity;
            end
            default: ;
        endcase
    end

    assign ps2_clk_oe = clk_oe_q;
    assign ps2_dat_oe = dat_oe_q;
    assign busy       = busy_q;
    assign tx_ready   = ready_q;
    assign done       = done_q;
    assign error      = err_q;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Directed plus randomized bench for ps2_host_tx with an open-collector PS/2 device model.
module tb_ps2_host_tx;

    localparam int unsigned INH  = 2500;
    localparam int unsigned TMO  = 600;
    localparam int          HALF = 15;
    localparam int          LIM  = 20000;

    logic       clk25 = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] tx_data = 8'h00;
    logic       tx_valid = 1'b0;
    logic       dev_clk_low = 1'b0;
    logic       dev_dat_low = 1'b0;
    logic       tx_ready, ps2_clk_oe, ps2_dat_oe, busy, done, error;

    wire clk_line = ~ps2_clk_oe & ~dev_clk_low;
    wire dat_line = ~ps2_dat_oe & ~dev_dat_low;

    always #5 clk25 = ~clk25;

    ps2_host_tx #(.INHIBIT_CYCLES(INH), .TIMEOUT_CYCLES(TMO)) dut (
        .clk25      (clk25),
        .rst_n      (rst_n),
        .tx_data    (tx_data),
        .tx_valid   (tx_valid),
        .tx_ready   (tx_ready),
        .ps2_clk_in (clk_line),
        .ps2_dat_in (dat_line),
        .ps2_clk_oe (ps2_clk_oe),
        .ps2_dat_oe (ps2_dat_oe),
        .busy       (busy),
        .done       (done),
        .error      (error)
    );

    int checks = 0, errors = 0;
    int cyc = 0;
    int done_cnt = 0, err_cnt = 0, err_cyc = 0, fall_cyc = 0;
    int oe_run = 0, last_run = 0, clk_rise = 0, dat_rise = 0;
    logic prev_clk_oe = 1'b0, prev_dat_oe = 1'b0;

    always @(posedge clk25) cyc <= cyc + 1;

    // Pulse counters and clock-inhibit timing observed on the falling clock edge.
    always @(negedge clk25) begin
        prev_clk_oe <= ps2_clk_oe;
        prev_dat_oe <= ps2_dat_oe;
        if (done === 1'b1) done_cnt <= done_cnt + 1;
        if (error === 1'b1) begin
            err_cnt <= err_cnt + 1;
            err_cyc <= cyc;
        end
        if (ps2_clk_oe === 1'b1) oe_run <= oe_run + 1;
        else if (oe_run != 0) begin
            last_run <= oe_run;
            oe_run   <= 0;
        end
        if (ps2_clk_oe === 1'b1 && prev_clk_oe !== 1'b1) clk_rise <= cyc;
        if (ps2_clk_oe === 1'b1 && ps2_dat_oe === 1'b1 && prev_dat_oe !== 1'b1) dat_rise <= cyc;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Line image of a host frame, LSB-first: start 0, data, odd parity, stop 1.
    function automatic logic [10:0] model_bits(input logic [7:0] d);
        logic par;
        par = ($countones(d) % 2 == 0);
        return {1'b1, par, d, 1'b0};
    endfunction

    task automatic send(input logic [7:0] b);
        int t = 0;
        while (tx_ready !== 1'b1 && t < LIM) begin
            @(negedge clk25);
            t++;
        end
        check("send_ready", tx_ready, 1);
        tx_data  = b;
        tx_valid = 1'b1;
        @(negedge clk25);
        tx_valid = 1'b0;
        check("accept_clk_oe", ps2_clk_oe, 1);
        check("accept_busy", {tx_ready, busy}, 2'b01);
    endtask

    // Device side: waits for request-to-send, clocks n_edges, samples data before each fall.
    task automatic dev_frame(input bit ack, input int n_edges, output logic [10:0] seen);
        int t = 0;
        seen = '0;
        while (ps2_clk_oe !== 1'b1 && t < LIM) begin @(negedge clk25); t++; end
        while (ps2_clk_oe !== 1'b0 && t < LIM) begin @(negedge clk25); t++; end
        check("dev_rts_seen", (t < LIM) ? 1 : 0, 1);
        repeat (HALF) @(negedge clk25);
        for (int i = 1; i <= n_edges; i++) begin
            if (i <= 11) seen[i-1] = dat_line;
            if (i == 11 && ack) dev_dat_low = 1'b1;
            repeat (2) @(negedge clk25);
            dev_clk_low = 1'b1;
            fall_cyc    = cyc;
            repeat (HALF) @(negedge clk25);
            dev_clk_low = 1'b0;
            repeat (HALF) @(negedge clk25);
        end
        dev_dat_low = 1'b0;
    endtask

    task automatic wait_end(output bit got_done, output bit got_err);
        int t = 0;
        while (done !== 1'b1 && error !== 1'b1 && t < LIM) begin
            @(negedge clk25);
            t++;
        end
        check("end_seen", (t < LIM) ? 1 : 0, 1);
        got_done = done;
        got_err  = error;
        check("end_lines_released", {ps2_clk_oe, ps2_dat_oe}, 2'b00);
        @(negedge clk25);
        check("end_single_pulse", {done, error}, 2'b00);
        check("end_ready_next", {tx_ready, busy}, 2'b10);
    endtask

    task automatic run_frame(input logic [7:0] d, input bit ack, input string tag);
        logic [10:0] seen;
        bit gd, ge;
        int d0 = done_cnt;
        int e0 = err_cnt;
        send(d);
        fork
            dev_frame(ack, 11, seen);
            wait_end(gd, ge);
        join
        repeat (5) @(negedge clk25);
        check({tag, "_bits"}, 32'(seen), 32'(model_bits(d)));
        check({tag, "_outcome"}, {gd, ge}, {ack, ~ack});
        check({tag, "_done_cnt"}, done_cnt - d0, ack ? 1 : 0);
        check({tag, "_err_cnt"}, err_cnt - e0, ack ? 0 : 1);
        check({tag, "_clk_oe_len"}, last_run, INH + 1);
        check({tag, "_dat_oe_delay"}, dat_rise - clk_rise, INH);
    endtask

    initial begin
        logic [10:0] seen, exp_bits;
        bit gd, ge;
        int d0, e0;

        repeat (3) @(negedge clk25);
        check("rst_outputs", {tx_ready, busy, done, error, ps2_clk_oe, ps2_dat_oe}, 6'b100000);
        rst_n = 1'b1;
        repeat (3) @(negedge clk25);

        run_frame(8'hED, 1'b1, "ed");
        run_frame(8'hF4, 1'b1, "f4");
        run_frame(8'h00, 1'b1, "zero");
        run_frame(8'hC3, 1'b0, "nack");

        // Device stops clocking after the fourth edge.
        e0 = err_cnt;
        send(8'hA5);
        fork
            dev_frame(1'b1, 4, seen);
            wait_end(gd, ge);
        join
        exp_bits = model_bits(8'hA5);
        check("tmo_bits", 32'(seen[3:0]), 32'(exp_bits[3:0]));
        check("tmo_outcome", {gd, ge}, 2'b01);
        check("tmo_latency", err_cyc - fall_cyc, TMO + 3);
        check("tmo_err_cnt", err_cnt - e0, 1);

        // A request while busy is dropped, not queued.
        d0 = done_cnt;
        send(8'hFF);
        fork
            dev_frame(1'b1, 11, seen);
            wait_end(gd, ge);
            begin
                repeat (INH + 100) @(negedge clk25);
                tx_data  = 8'h55;
                tx_valid = 1'b1;
                @(negedge clk25);
                tx_valid = 1'b0;
            end
        join
        repeat (60) @(negedge clk25);
        check("busy_req_bits", 32'(seen), 32'(model_bits(8'hFF)));
        check("busy_req_done", done_cnt - d0, 1);
        check("busy_req_no_frame", {ps2_clk_oe, tx_ready}, 2'b01);

        // Reset in the middle of the data phase.
        d0 = done_cnt;
        e0 = err_cnt;
        send(8'hED);
        dev_frame(1'b1, 5, seen);
        check("pre_rst_dat_oe", {ps2_clk_oe, ps2_dat_oe}, 2'b01);
        @(negedge clk25);
        rst_n = 1'b0;
        #1;
        check("rst_async_release", {ps2_clk_oe, ps2_dat_oe}, 2'b00);
        check("rst_async_ready", {tx_ready, busy}, 2'b10);
        repeat (4) @(negedge clk25);
        rst_n = 1'b1;
        repeat (4) @(negedge clk25);
        check("rst_no_pulse", {done_cnt - d0, err_cnt - e0}, 64'd0);
        run_frame(8'hED, 1'b1, "post_rst");

        for (int i = 0; i < 4; i++)
            run_frame(8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)), "rand");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
